// File: rtl/alu_pkg.sv
// Shared ALU opcode/state types, LFSR step and the golden ALU model used by
// the BIST engines.
package alu_pkg;

    localparam int          MAX_W     = 16;
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    typedef enum logic [2:0] {
        ADD    = 3'd0,
        SUB    = 3'd1,
        AND    = 3'd2,
        OR     = 3'd3,
        XOR    = 3'd4,
        SLL    = 3'd5,
        SRL    = 3'd6,
        PASS_A = 3'd7
    } alu_op_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } bist_state_t;

    // Right-shifting Galois form: the bit shifted out folds the tap word back in.
    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0);
    endfunction

    // Operands arrive zero-extended to MAX_W; w is the live datapath width.
    function automatic logic [MAX_W-1:0] alu_ref(input logic [MAX_W-1:0] a,
                                                 input logic [MAX_W-1:0] b,
                                                 input alu_op_t          op,
                                                 input int unsigned      w);
        logic [MAX_W-1:0] mask;
        logic [MAX_W-1:0] am;
        logic [MAX_W-1:0] r;
        logic [3:0]       sh;
        mask = MAX_W'((32'h1 << w) - 32'h1);
        am   = a & mask;
        sh   = b[3:0];
        case (op)
            ADD:     r = a + b;
            SUB:     r = a - b;
            AND:     r = a & b;
            OR:      r = a | b;
            XOR:     r = a ^ b;
            SLL:     r = (32'(sh) >= w) ? '0 : (am << sh);
            SRL:     r = (32'(sh) >= w) ? '0 : (am >> sh);
            PASS_A:  r = a;
            default: r = '0;
        endcase
        return r & mask;
    endfunction

endpackage

// File: rtl/bist_lfsr.sv
// 32-bit Galois LFSR with reload and step; state reflects a same-cycle reload
// so the caller can consume the seed value immediately.
module bist_lfsr
    import alu_pkg::*;
#(
    parameter logic [31:0] SEED = 32'hACE1_0001
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        step,
    output logic [31:0] state
);

    logic [31:0] state_q;
    logic [31:0] state_d;
    logic [31:0] base;

    always_comb begin
        base    = load ? SEED : state_q;
        state_d = step ? lfsr_next(base) : base;
        state   = base;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

endmodule

// File: rtl/alu_bist.sv
// ALU self-test engine: issues LFSR vectors to an ALU with fixed latency LAT,
// checks each returned result against alu_ref and accumulates statistics.
module alu_bist
    import alu_pkg::*;
#(
    parameter int          DATA_W  = 16,
    parameter int          LAT     = 1,
    parameter int          ITER_W  = 16,
    parameter int          BOUND_W = 4,
    parameter logic [31:0] SEED    = 32'hACE1_0001
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ITER_W-1:0] iterations,
    input  logic              bounded,
    output logic [DATA_W-1:0] dut_a,
    output logic [DATA_W-1:0] dut_b,
    output alu_op_t           dut_op,
    output logic              dut_valid,
    input  logic [DATA_W-1:0] dut_result,
    output logic              busy,
    output logic              done,
    output logic [ITER_W-1:0] iter_count,
    output logic [ITER_W-1:0] fail_count,
    output logic              first_fail_valid,
    output logic [ITER_W-1:0] first_fail_iter
);

    localparam logic [31:0]       SEED_EFF = (SEED == 32'd0) ? 32'd1 : SEED;
    localparam logic [DATA_W-1:0] BMASK    = DATA_W'((32'd1 << BOUND_W) - 32'd1);

    bist_state_t       state_q, state_d;
    logic [ITER_W-1:0] left_q, left_d;
    logic              bnd_q, bnd_d;
    logic [DATA_W-1:0] a_p0_q, a_p0_d;
    logic [DATA_W-1:0] b_p0_q, b_p0_d;
    alu_op_t           op_p0_q, op_p0_d;
    logic              vld_p0_q, vld_p0_d;
    logic [DATA_W-1:0] exp_p0_q, exp_p0_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic [ITER_W-1:0] fail_q, fail_d;
    logic              ffv_q, ffv_d;
    logic [ITER_W-1:0] ffi_q, ffi_d;

    logic              accept;
    logic              issue;
    logic [31:0]       lfsr_cur;
    logic [DATA_W-1:0] va, vb;
    alu_op_t           vop;
    logic              chk_vld;
    logic [DATA_W-1:0] chk_exp;
    logic              pending;

    bist_lfsr #(.SEED(SEED_EFF)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept),
        .step  (issue),
        .state (lfsr_cur)
    );

    always_comb begin
        state_d  = state_q;
        left_d   = left_q;
        bnd_d    = bnd_q;
        a_p0_d   = a_p0_q;
        b_p0_d   = b_p0_q;
        op_p0_d  = op_p0_q;
        exp_p0_d = exp_p0_q;
        vld_p0_d = 1'b0;
        iter_d   = iter_q;
        fail_d   = fail_q;
        ffv_d    = ffv_q;
        ffi_d    = ffi_q;
        issue    = 1'b0;
        accept   = start && ((state_q == S_IDLE) || (state_q == S_DONE));

        // First vector of a run must honour the bounded input before it is registered.
        va  = lfsr_cur[DATA_W-1:0];
        vb  = lfsr_cur[16 +: DATA_W];
        vop = alu_op_t'(lfsr_cur[2:0] ^ lfsr_cur[18:16]);
        if (accept ? bounded : bnd_q) begin
            va = va & BMASK;
            vb = vb & BMASK;
        end

        if (chk_vld) begin
            iter_d = iter_q + ITER_W'(1);
            if (chk_exp != dut_result) begin
                if (fail_q != '1) begin
                    fail_d = fail_q + ITER_W'(1);
                end
                if (!ffv_q) begin
                    ffv_d = 1'b1;
                    ffi_d = iter_q;
                end
            end
        end

        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    bnd_d  = bounded;
                    iter_d = '0;
                    fail_d = '0;
                    ffv_d  = 1'b0;
                    ffi_d  = '0;
                    if (iterations == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_RUN;
                        issue   = 1'b1;
                        left_d  = iterations - ITER_W'(1);
                    end
                end
            end
            S_RUN: begin
                if (left_q != '0) begin
                    issue  = 1'b1;
                    left_d = left_q - ITER_W'(1);
                end else begin
                    state_d = (LAT == 0) ? S_DONE : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!pending) begin
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (issue) begin
            a_p0_d   = va;
            b_p0_d   = vb;
            op_p0_d  = vop;
            vld_p0_d = 1'b1;
            exp_p0_d = DATA_W'(alu_ref(MAX_W'(va), MAX_W'(vb), vop, DATA_W));
        end
    end

    // Issue stage p0: vector presented to the DUT, expected value alongside.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            left_q   <= '0;
            bnd_q    <= 1'b0;
            a_p0_q   <= '0;
            b_p0_q   <= '0;
            op_p0_q  <= ADD;
            vld_p0_q <= 1'b0;
            iter_q   <= '0;
            fail_q   <= '0;
            ffv_q    <= 1'b0;
            ffi_q    <= '0;
        end else begin
            state_q  <= state_d;
            left_q   <= left_d;
            bnd_q    <= bnd_d;
            a_p0_q   <= a_p0_d;
            b_p0_q   <= b_p0_d;
            op_p0_q  <= op_p0_d;
            vld_p0_q <= vld_p0_d;
            iter_q   <= iter_d;
            fail_q   <= fail_d;
            ffv_q    <= ffv_d;
            ffi_q    <= ffi_d;
        end
    end

    always_ff @(posedge clk) begin
        exp_p0_q <= exp_p0_d;
    end

    generate
        if (LAT == 0) begin : g_nodelay
            always_comb begin
                chk_vld = vld_p0_q;
                chk_exp = exp_p0_q;
                pending = vld_p0_q;
            end
        end else begin : g_delay
            logic [LAT-1:0]    vld_pd_q, vld_pd_d;
            logic [DATA_W-1:0] exp_pd_q [LAT];
            logic [DATA_W-1:0] exp_pd_d [LAT];

            always_comb begin
                vld_pd_d[0] = vld_p0_q;
                exp_pd_d[0] = exp_p0_q;
                for (int i = 1; i < LAT; i++) begin
                    vld_pd_d[i] = vld_pd_q[i-1];
                    exp_pd_d[i] = exp_pd_q[i-1];
                end
                // Vectors issue back to back, so the run is drained once nothing
                // remains upstream of the compare stage.
                pending = vld_p0_q;
                for (int i = 0; i < LAT - 1; i++) begin
                    pending = pending | vld_pd_q[i];
                end
                chk_vld = vld_pd_q[LAT-1];
                chk_exp = exp_pd_q[LAT-1];
            end

            // Delay stages pd0..pd(LAT-1): expected value waits for the DUT result.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vld_pd_q <= '0;
                end else begin
                    vld_pd_q <= vld_pd_d;
                end
            end

            always_ff @(posedge clk) begin
                exp_pd_q <= exp_pd_d;
            end
        end
    endgenerate

    always_comb begin
        dut_a            = a_p0_q;
        dut_b            = b_p0_q;
        dut_op           = op_p0_q;
        dut_valid        = vld_p0_q;
        busy             = (state_q == S_RUN) || (state_q == S_DRAIN);
        done             = (state_q == S_DONE);
        iter_count       = iter_q;
        fail_count       = fail_q;
        first_fail_valid = ffv_q;
        first_fail_iter  = ffi_q;
    end

endmodule

// File: tb/tb_alu_bist.sv
// Bench for alu_bist: loopback ALUs at latencies 1, 0 and 8, with an
// independent vector/ALU model and optional fault on ADD results.
module tb_alu_bist;

    localparam logic [31:0] SEED = 32'hACE1_0001;

    logic        clk;
    logic        rst_n;
    logic        start, start0, start8;
    logic [15:0] iterations;
    logic        bounded;
    bit          flip_add;

    logic [15:0] a, b, res;
    logic [2:0]  op;
    logic        dv, busy, done, ffv;
    logic [15:0] iter, fail, ffi;

    logic [15:0] a0, b0, res0, iter0, fail0, ffi0;
    logic [2:0]  op0;
    logic        dv0, busy0, done0, ffv0;

    logic [15:0] a8, b8, res8, iter8, fail8, ffi8;
    logic [2:0]  op8;
    logic        dv8, busy8, done8, ffv8;
    logic [15:0] pipe8 [8];

    int checks = 0;
    int errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] model_lfsr(input logic [31:0] s);
        logic [31:0] t;
        t = s >> 1;
        if (s[0]) t = t ^ 32'h8020_0003;
        return t;
    endfunction

    function automatic logic [15:0] model_alu(input logic [15:0] x, input logic [15:0] y,
                                              input logic [2:0] o);
        case (o)
            3'd0:    return x + y;
            3'd1:    return x - y;
            3'd2:    return x & y;
            3'd3:    return x | y;
            3'd4:    return x ^ y;
            3'd5:    return x << y[3:0];
            3'd6:    return x >> y[3:0];
            default: return x;
        endcase
    endfunction

    always @(posedge clk) res <= model_alu(a, b, op) ^ {15'd0, (flip_add && op == 3'd0)};
    assign res0 = model_alu(a0, b0, op0);
    always @(posedge clk) begin
        pipe8[0] <= model_alu(a8, b8, op8);
        for (int i = 1; i < 8; i++) pipe8[i] <= pipe8[i-1];
    end
    assign res8 = pipe8[7];

    alu_bist #(.LAT(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .iterations(iterations), .bounded(bounded),
        .dut_a(a), .dut_b(b), .dut_op(op), .dut_valid(dv), .dut_result(res),
        .busy(busy), .done(done), .iter_count(iter), .fail_count(fail),
        .first_fail_valid(ffv), .first_fail_iter(ffi)
    );

    alu_bist #(.LAT(0)) u_l0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .iterations(iterations), .bounded(bounded),
        .dut_a(a0), .dut_b(b0), .dut_op(op0), .dut_valid(dv0), .dut_result(res0),
        .busy(busy0), .done(done0), .iter_count(iter0), .fail_count(fail0),
        .first_fail_valid(ffv0), .first_fail_iter(ffi0)
    );

    alu_bist #(.LAT(8)) u_l8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .iterations(iterations), .bounded(bounded),
        .dut_a(a8), .dut_b(b8), .dut_op(op8), .dut_valid(dv8), .dut_result(res8),
        .busy(busy8), .done(done8), .iter_count(iter8), .fail_count(fail8),
        .first_fail_valid(ffv8), .first_fail_iter(ffi8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Runs the LAT=1 engine; cycle 0 is the cycle start is presented.
    task automatic run_main(input int n, input bit bnd, input bit flip,
                            output int done_cyc, output int n_add, output int first_add,
                            output int max_ab, output int vcnt, output int verr,
                            output logic [31:0] hash);
        logic [31:0] s;
        logic [15:0] ea, eb;
        logic [2:0]  eop;
        int          cyc;
        flip_add = flip;
        @(posedge clk); #1;
        iterations = 16'(n);
        bounded    = bnd;
        start      = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        s = SEED; cyc = 1; done_cyc = -1; n_add = 0; first_add = -1;
        max_ab = 0; vcnt = 0; verr = 0; hash = 32'd0;
        while (cyc < 3000) begin
            @(negedge clk);
            if (dv) begin
                ea  = s[15:0];
                eb  = s[31:16];
                eop = s[2:0] ^ s[18:16];
                if (bnd) begin
                    ea = ea % 16;
                    eb = eb % 16;
                end
                if (a !== ea || b !== eb || op !== eop) verr++;
                if (eop == 3'd0) begin
                    if (first_add < 0) first_add = vcnt;
                    n_add++;
                end
                if (int'(a) > max_ab) max_ab = int'(a);
                if (int'(b) > max_ab) max_ab = int'(b);
                hash = {hash[30:0], hash[31]} ^ {a, b} ^ {29'd0, op};
                s = model_lfsr(s);
                vcnt++;
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic run_lat(input bit w8, input int n, output int done_cyc);
        int cyc;
        @(posedge clk); #1;
        iterations = 16'(n);
        bounded    = 1'b0;
        if (w8) start8 = 1'b1; else start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        start8 = 1'b0;
        cyc = 1; done_cyc = -1;
        while (cyc < 3000) begin
            @(negedge clk);
            if (w8 ? done8 : done0) begin
                done_cyc = cyc;
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    initial begin
        int          dc, nadd, fadd, mab, vc, ve;
        logic [31:0] h1, h2;
        rst_n = 1'b0; start = 1'b0; start0 = 1'b0; start8 = 1'b0;
        iterations = '0; bounded = 1'b0; flip_add = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_a", a, 0);
        check("rst_b", b, 0);
        check("rst_op", op, 0);
        check("rst_valid", dv, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_iter", iter, 0);
        check("rst_fail", fail, 0);
        check("rst_ffv", ffv, 0);

        // Golden loopback, 1000 vectors.
        run_main(1000, 1'b0, 1'b0, dc, nadd, fadd, mab, vc, ve, h1);
        check("gold_done_cyc", dc, 1002);
        check("gold_vcnt", vc, 1000);
        check("gold_vec_err", ve, 0);
        check("gold_iter", iter, 1000);
        check("gold_fail", fail, 0);
        check("gold_ffv", ffv, 0);
        check("gold_busy", busy, 0);

        // Fault on ADD results only.
        run_main(200, 1'b0, 1'b1, dc, nadd, fadd, mab, vc, ve, h1);
        check("flip_done_cyc", dc, 202);
        check("flip_iter", iter, 200);
        check("flip_fail", fail, 32'(nadd));
        check("flip_ffv", ffv, (nadd > 0) ? 1 : 0);
        check("flip_ffi", ffi, 32'(fadd));

        // Zero iterations.
        run_main(0, 1'b0, 1'b0, dc, nadd, fadd, mab, vc, ve, h1);
        check("zero_done_cyc", dc, 1);
        check("zero_vcnt", vc, 0);
        check("zero_iter", iter, 0);
        check("zero_fail", fail, 0);
        check("zero_ffv", ffv, 0);

        // Bounded mode, repeated for stream reproducibility.
        run_main(500, 1'b1, 1'b0, dc, nadd, fadd, mab, vc, ve, h1);
        check("bnd1_max", (mab < 16) ? 1 : 0, 1);
        check("bnd1_vec_err", ve, 0);
        check("bnd1_iter", iter, 500);
        check("bnd1_fail", fail, 0);
        run_main(500, 1'b1, 1'b0, dc, nadd, fadd, mab, vc, ve, h2);
        check("bnd2_max", (mab < 16) ? 1 : 0, 1);
        check("bnd_repeat_hash", h2, h1);
        check("bnd2_done_cyc", dc, 502);

        // Latency 0 and 8 builds.
        run_lat(1'b0, 100, dc);
        check("l0_done_cyc", dc, 101);
        check("l0_iter", iter0, 100);
        check("l0_fail", fail0, 0);
        run_lat(1'b1, 100, dc);
        check("l8_done_cyc", dc, 109);
        check("l8_iter", iter8, 100);
        check("l8_fail", fail8, 0);

        // Ignored start during RUN, then asynchronous reset mid-run.
        @(posedge clk); #1;
        iterations = 16'd300; bounded = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        iterations = 16'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("ign_busy", busy, 1);
        check("ign_valid", dv, 1);
        check("ign_iter", iter, 30);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", dv, 0);
        check("arst_busy", busy, 0);
        check("arst_a", a, 0);
        check("arst_op", op, 0);
        check("arst_iter", iter, 0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_main(100, 1'b0, 1'b0, dc, nadd, fadd, mab, vc, ve, h1);
        check("post_done_cyc", dc, 102);
        check("post_iter", iter, 100);
        check("post_fail", fail, 0);
        check("post_vec_err", ve, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
